// File: rtl/crossbar_pkg.sv
// Shared state encoding, default index width and saturating increment for the scoreboard.
// Pure declarations: no latency, no flow control.
package crossbar_pkg;

  localparam int IDX_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } sb_state_t;

  // Holds at 2**w-1 instead of wrapping; callers cast back to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max;
    max = (32'h1 << w) - 32'h1;
    return (v >= max) ? max : v + 32'h1;
  endfunction

endpackage

// File: rtl/sb_watchdog.sv
// Idle-cycle watchdog: expired pulses combinationally on the TIMEOUT-th consecutive idle cycle.
// Clears whenever disabled or kicked; no backpressure.
module sb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = en && !kick && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || kick) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/crossbar_scoreboard.sv
// Scoreboard for crossbar driver results: counts, first miss, watchdog, verdict 1 cycle after last result.
// No backpressure (one result per pulse); SCOREBOARD_STOP_ON_MISS_EN ends a run at its first miss.
module crossbar_scoreboard
  import crossbar_pkg::*;
#(
  parameter int NUM_VECTORS = 1024,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int CNT_W       = 11,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             hit,
  input  logic             miss,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             first_miss_vld,
  output logic [IDX_W-1:0] first_miss_idx,
  output logic             proto_err,
  output logic             timeout
);

  sb_state_t state, state_nxt;

  logic           in_run, res_vld, both, last, stop_miss, enter_run, wd_expired;
  logic [CNT_W:0] total;

  assign in_run    = (state == ST_RUN);
  assign both      = in_run && hit && miss;
  assign res_vld   = in_run && (hit ^ miss);
  assign total     = {1'b0, hit_cnt} + {1'b0, miss_cnt};
  assign last      = res_vld && (total == (CNT_W + 1)'(NUM_VECTORS - 1));
  assign enter_run = start && !clear && !in_run;
`ifdef SCOREBOARD_STOP_ON_MISS_EN
  assign stop_miss = res_vld && miss;
`else
  assign stop_miss = 1'b0;
`endif

  assign busy = in_run;
  assign done = (state == ST_DONE);

  sb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (in_run),
    .kick    (hit || miss),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (both)                    state_nxt = ST_ERR;
          else if (last || stop_miss)  state_nxt = ST_DONE;
          else if (wd_expired)         state_nxt = ST_ERR;
        end
        default: if (start) state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      first_miss_vld <= 1'b0;
      first_miss_idx <= '0;
      proto_err      <= 1'b0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
    end else if (clear || enter_run) begin
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      first_miss_vld <= 1'b0;
      first_miss_idx <= '0;
      proto_err      <= 1'b0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
    end else if (in_run) begin
      if (both) begin
        proto_err <= 1'b1;
      end else if (res_vld) begin
        if (hit) begin
          hit_cnt <= CNT_W'(sat_inc(32'(hit_cnt), CNT_W));
        end else begin
          miss_cnt <= CNT_W'(sat_inc(32'(miss_cnt), CNT_W));
          if (!first_miss_vld) begin
            first_miss_vld <= 1'b1;
            first_miss_idx <= total[IDX_W-1:0];
          end
        end
        // Verdict is latched together with the final count.
        if (last || stop_miss) pass <= hit && (miss_cnt == '0);
      end else if (wd_expired) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_scoreboard.sv
module tb_crossbar_scoreboard;

  localparam int NV    = 8;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             hit = 1'b0;
  logic             miss = 1'b0;
  logic             busy, done, pass, first_miss_vld, proto_err, timeout;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic [IDX_W-1:0] first_miss_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  crossbar_scoreboard #(
    .NUM_VECTORS(NV), .IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .hit(hit), .miss(miss),
    .busy(busy), .done(done), .pass(pass), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .first_miss_vld(first_miss_vld), .first_miss_idx(first_miss_idx),
    .proto_err(proto_err), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic result(input logic h, input logic m);
    hit  = h;
    miss = m;
    tick();
    hit  = 1'b0;
    miss = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy, done, pass, hit_cnt, miss_cnt, first_miss_vld, first_miss_idx, proto_err, timeout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b hit=%0d miss=%0d fmv=%b pe=%b to=%b, want all 0",
               busy, done, pass, hit_cnt, miss_cnt, first_miss_vld, proto_err, timeout);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_all_hits();
    pulse_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL hits_busy: got %b want 1", busy); end
    for (int i = 0; i < NV; i++) begin
      if (i == NV - 1) begin
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL hits_early_done: got %b want 0", done); end
      end
      result(1'b1, 1'b0);
      if (i < NV - 1) tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
      bad++;
      $display("FAIL hits_verdict: done=%b busy=%b pass=%b want 1 0 1", done, busy, pass);
    end
    total++;
    if (hit_cnt !== 5'd8 || miss_cnt !== 5'd0 || first_miss_vld !== 1'b0) begin
      bad++;
      $display("FAIL hits_counts: hit=%0d miss=%0d fmv=%b want 8 0 0", hit_cnt, miss_cnt, first_miss_vld);
    end
  endtask

  task automatic test_misses();
    logic [7:0] pat;
    pat = 8'b0001_0100;  // bit i set = miss for result i: H,H,M,H,M,H,H,H
    pulse_start();
    for (int i = 0; i < NV; i++) begin
      result(!pat[i], pat[i]);
`ifdef SCOREBOARD_STOP_ON_MISS_EN
      if (i == 2) break;
`endif
    end
    total++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL miss_verdict: done=%b pass=%b want 1 0", done, pass);
    end
`ifdef SCOREBOARD_STOP_ON_MISS_EN
    total++;
    if (hit_cnt !== 5'd2 || miss_cnt !== 5'd1) begin
      bad++;
      $display("FAIL miss_counts: hit=%0d miss=%0d want 2 1", hit_cnt, miss_cnt);
    end
`else
    total++;
    if (hit_cnt !== 5'd6 || miss_cnt !== 5'd2) begin
      bad++;
      $display("FAIL miss_counts: hit=%0d miss=%0d want 6 2", hit_cnt, miss_cnt);
    end
`endif
    total++;
    if (first_miss_vld !== 1'b1 || first_miss_idx !== 4'd2) begin
      bad++;
      $display("FAIL first_miss: vld=%b idx=%0d want 1 2", first_miss_vld, first_miss_idx);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    for (int i = 0; i < 3; i++) result(1'b1, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    total++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: timeout=%b busy=%b want 0 1", timeout, busy);
    end
    tick();
    total++;
    if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || hit_cnt !== 5'd3) begin
      bad++;
      $display("FAIL timeout_err: timeout=%b busy=%b done=%b hit=%0d want 1 0 0 3", timeout, busy, done, hit_cnt);
    end
    pulse_start();
    total++;
    if (timeout !== 1'b0 || hit_cnt !== 5'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_restart: timeout=%b hit=%0d busy=%b want 0 0 1", timeout, hit_cnt, busy);
    end
  endtask

  task automatic test_proto_err();
    result(1'b1, 1'b0);
    result(1'b1, 1'b0);
    result(1'b1, 1'b1);
    total++;
    if (proto_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL proto_err: pe=%b busy=%b done=%b want 1 0 0", proto_err, busy, done);
    end
    total++;
    if (hit_cnt !== 5'd2 || miss_cnt !== 5'd0) begin
      bad++;
      $display("FAIL proto_counts: hit=%0d miss=%0d want 2 0", hit_cnt, miss_cnt);
    end
    result(1'b1, 1'b0);
    total++;
    if (hit_cnt !== 5'd2) begin bad++; $display("FAIL err_ignores_hit: hit=%0d want 2", hit_cnt); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) result(1'b1, 1'b0);
    total++;
    if (hit_cnt !== 5'd4) begin bad++; $display("FAIL pre_reset_hits: hit=%0d want 4", hit_cnt); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || hit_cnt !== 5'd0 || done !== 1'b0 || pass !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: busy=%b hit=%0d done=%b pass=%b want 0 0 0 0", busy, hit_cnt, done, pass);
    end
    tick();
    rst = 1'b1;
    result(1'b1, 1'b0);
    result(1'b0, 1'b1);
    total++;
    if (hit_cnt !== 5'd0 || miss_cnt !== 5'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignores: hit=%0d miss=%0d busy=%b want 0 0 0", hit_cnt, miss_cnt, busy);
    end
  endtask

  task automatic test_start_clear();
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL clear_wins: busy=%b done=%b want 0 0", busy, done);
    end
    pulse_start();
    result(1'b1, 1'b0);
    result(1'b1, 1'b0);
    pulse_start();
    total++;
    if (hit_cnt !== 5'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_in_run: hit=%0d busy=%b want 2 1", hit_cnt, busy);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL clear_run: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_all_hits();
    test_misses();
    test_timeout();
    test_proto_err();
    test_async_reset();
    test_start_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
